// File: rtl/vgpr_wr_pkg.sv
// Shared widths and slicing helper for the VGPR write-port arbitration path.
// Imported by the arbiter and the write-port mux top level.
package vgpr_wr_pkg;

  localparam int NUM_PORTS = 8;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 2048;
  localparam int MASK_W    = 64;
  localparam int PTR_W     = $clog2(NUM_PORTS);

  typedef logic [PTR_W-1:0] port_idx_t;

  // Low bit of port idx inside a flat bus of width-bit fields.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter_8.sv
// Combinational 8-way round-robin arbiter: first requester at or after ptr wins.
// Shared between the VGPR and SGPR write paths.
module rr_arbiter_8
  import vgpr_wr_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_vld
);

  logic [2:0] scan_idx;

  // Scan farthest-first so the nearest requester to ptr is the last write.
  always_comb begin
    scan_idx  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      scan_idx = ptr + k[2:0];
      if (req[scan_idx]) begin
        grant_idx = scan_idx;
        grant_vld = 1'b1;
      end
    end
  end

  assign grant = grant_vld ? (8'b1 << grant_idx) : 8'b0;

endmodule

// File: rtl/wr_port_arb_8to1.sv
// Eight producer write ports, each with a one-entry holding buffer, merged
// round-robin onto one registered VGPR write port.
module wr_port_arb_8to1
  import vgpr_wr_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          port_wr_en,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_wr_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_wr_data,
  input  logic [NUM_PORTS*MASK_W-1:0]   port_wr_mask,
  output logic [NUM_PORTS-1:0]          port_wr_ready,
  output logic                          muxed_port_wr_en,
  output logic [ADDR_W-1:0]             muxed_port_wr_addr,
  output logic [DATA_W-1:0]             muxed_port_wr_data,
  output logic [MASK_W-1:0]             muxed_port_wr_mask,
  output logic                          wr_pending
);

  logic [NUM_PORTS-1:0] hold_valid_q;
  logic [NUM_PORTS-1:0] hold_valid_d;
  logic [ADDR_W-1:0]    hold_addr_q [NUM_PORTS];
  logic [DATA_W-1:0]    hold_data_q [NUM_PORTS];
  logic [MASK_W-1:0]    hold_mask_q [NUM_PORTS];

  port_idx_t            rr_ptr_q;
  port_idx_t            rr_ptr_d;
  logic [NUM_PORTS-1:0] grant;
  port_idx_t            grant_idx;
  logic                 grant_vld;

  rr_arbiter_8 u_arb (
    .req       (hold_valid_q),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_hold
      logic accept;

      // A granted entry frees its slot this cycle, so a new write can refill it.
      assign port_wr_ready[gi] = ~rst & (~hold_valid_q[gi] | grant[gi]);
      assign accept            = port_wr_en[gi] & port_wr_ready[gi];
      assign hold_valid_d[gi]  = accept | (hold_valid_q[gi] & ~grant[gi]);

      // Payload needs no reset: it is only observed through hold_valid_q.
      always_ff @(posedge clk) begin
        if (accept) begin
          hold_addr_q[gi] <= port_wr_addr[slice_lo(gi, ADDR_W) +: ADDR_W];
          hold_data_q[gi] <= port_wr_data[slice_lo(gi, DATA_W) +: DATA_W];
          hold_mask_q[gi] <= port_wr_mask[slice_lo(gi, MASK_W) +: MASK_W];
        end
      end
    end
  endgenerate

  assign rr_ptr_d = grant_vld ? grant_idx + 1'b1 : rr_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q       <= '0;
      rr_ptr_q           <= '0;
      muxed_port_wr_en   <= 1'b0;
      muxed_port_wr_addr <= '0;
      muxed_port_wr_data <= '0;
      muxed_port_wr_mask <= '0;
    end else begin
      hold_valid_q     <= hold_valid_d;
      rr_ptr_q         <= rr_ptr_d;
      muxed_port_wr_en <= grant_vld;
      if (grant_vld) begin
        muxed_port_wr_addr <= hold_addr_q[grant_idx];
        muxed_port_wr_data <= hold_data_q[grant_idx];
        muxed_port_wr_mask <= hold_mask_q[grant_idx];
      end
    end
  end

  assign wr_pending = (|hold_valid_q) | muxed_port_wr_en;

endmodule

// File: tb/tb_wr_port_arb_8to1.sv
// Randomised scoreboard bench for wr_port_arb_8to1: a behavioural model predicts
// each muxed write and the cycle it must appear; a monitor checks every cycle.
module tb_wr_port_arb_8to1;
  import vgpr_wr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst;
  logic [NUM_PORTS-1:0]        port_wr_en;
  logic [NUM_PORTS*ADDR_W-1:0] port_wr_addr;
  logic [NUM_PORTS*DATA_W-1:0] port_wr_data;
  logic [NUM_PORTS*MASK_W-1:0] port_wr_mask;
  logic [NUM_PORTS-1:0]        port_wr_ready;
  logic                        muxed_port_wr_en;
  logic [ADDR_W-1:0]           muxed_port_wr_addr;
  logic [DATA_W-1:0]           muxed_port_wr_data;
  logic [MASK_W-1:0]           muxed_port_wr_mask;
  logic                        wr_pending;

  wr_port_arb_8to1 dut (
    .clk                (clk),
    .rst                (rst),
    .port_wr_en         (port_wr_en),
    .port_wr_addr       (port_wr_addr),
    .port_wr_data       (port_wr_data),
    .port_wr_mask       (port_wr_mask),
    .port_wr_ready      (port_wr_ready),
    .muxed_port_wr_en   (muxed_port_wr_en),
    .muxed_port_wr_addr (muxed_port_wr_addr),
    .muxed_port_wr_data (muxed_port_wr_data),
    .muxed_port_wr_mask (muxed_port_wr_mask),
    .wr_pending         (wr_pending)
  );

  typedef struct {
    int                port;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
    int                due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: which ports hold an entry, entry contents, scan start.
  bit   m_pend [NUM_PORTS];
  exp_t m_ent  [NUM_PORTS];
  int   m_ptr;
  bit   m_out_vld;

  // Producers: a request stays asserted and unchanged until accepted.
  bit                p_en   [NUM_PORTS];
  logic [ADDR_W-1:0] p_addr [NUM_PORTS];
  logic [DATA_W-1:0] p_data [NUM_PORTS];
  logic [MASK_W-1:0] p_mask [NUM_PORTS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int w = 0; w < DATA_W / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic offer(input int i, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    if (!p_en[i]) begin
      p_en[i]   = 1'b1;
      p_addr[i] = a;
      p_data[i] = d;
      p_mask[i] = m;
    end
  endtask

  task automatic offer_rand(input int i);
    logic [MASK_W-1:0] m;
    m = ($urandom_range(0, 9) == 0) ? '0 : {$urandom, $urandom};
    offer(i, ADDR_W'($urandom), rand_data(), m);
  endtask

  // One clock: drive inputs, check ready/pending, then advance the model.
  task automatic cycle(input bit r);
    logic [NUM_PORTS-1:0] exp_ready;
    bit   any_pend;
    int   g;
    exp_t e;
    @(negedge clk);
    rst = r;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_wr_en[i]                     = p_en[i];
      port_wr_addr[i*ADDR_W +: ADDR_W]  = p_addr[i];
      port_wr_data[i*DATA_W +: DATA_W]  = p_data[i];
      port_wr_mask[i*MASK_W +: MASK_W]  = p_mask[i];
    end
    #1;
    g = -1;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (g < 0 && m_pend[(m_ptr + k) % NUM_PORTS]) g = (m_ptr + k) % NUM_PORTS;
    end
    any_pend = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      exp_ready[i] = !r && (!m_pend[i] || g == i);
      any_pend     = any_pend | m_pend[i];
    end
    check("port_wr_ready", 64'(port_wr_ready), 64'(exp_ready));
    check("wr_pending", 64'(wr_pending), 64'(any_pend | m_out_vld));

    if (r) begin
      for (int i = 0; i < NUM_PORTS; i++) m_pend[i] = 1'b0;
      m_ptr     = 0;
      m_out_vld = 1'b0;
    end else begin
      m_out_vld = (g >= 0);
      if (g >= 0) begin
        e     = m_ent[g];
        e.due = cyc + 1;
        exp_q.push_back(e);
        m_pend[g] = 1'b0;
        m_ptr     = (g + 1) % NUM_PORTS;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (p_en[i] && exp_ready[i]) begin
          m_pend[i]     = 1'b1;
          m_ent[i].port = i;
          m_ent[i].addr = p_addr[i];
          m_ent[i].data = p_data[i];
          m_ent[i].mask = p_mask[i];
          p_en[i]       = 1'b0;
        end
      end
    end
  endtask

  // Monitor: a write must appear exactly in the cycle the model scheduled it.
  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        mon_e = exp_q.pop_front();
        check("muxed_en", 64'(muxed_port_wr_en), 64'd1);
        check("muxed_addr", 64'(muxed_port_wr_addr), 64'(mon_e.addr));
        check("muxed_mask", muxed_port_wr_mask, mon_e.mask);
        checks++;
        if (muxed_port_wr_data !== mon_e.data) begin
          errors++;
          $display("FAIL muxed_data @cyc %0d port %0d: got low %h expected low %h (full word differs)",
                   cyc, mon_e.port, muxed_port_wr_data[63:0], mon_e.data[63:0]);
        end
      end else begin
        check("muxed_idle", 64'(muxed_port_wr_en), 64'd0);
      end
    end
  end

  int a1, a6;

  initial begin
    rst          = 1'b1;
    port_wr_en   = '0;
    port_wr_addr = '0;
    port_wr_data = '0;
    port_wr_mask = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      m_pend[i] = 1'b0;
      p_en[i]   = 1'b0;
      p_addr[i] = '0;
      p_data[i] = '0;
      p_mask[i] = '0;
    end
    m_ptr     = 0;
    m_out_vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mon_on = 1'b1;

    // Reset with all requests asserted, then release: all-port burst 0..7.
    for (int i = 0; i < NUM_PORTS; i++) offer(i, ADDR_W'(i), rand_data(), {$urandom, $urandom});
    cycle(1'b1);
    cycle(1'b1);
    repeat (12) cycle(1'b0);

    // Single write on port 3.
    offer(3, 10'h05A, {64{32'hA5A5_0F0F}}, 64'hFFFF_0000_FFFF_0000);
    repeat (5) cycle(1'b0);

    // Ports 1 and 6 continuously busy with incrementing addresses.
    a1 = 10'h100;
    a6 = 10'h200;
    for (int c = 0; c < 24; c++) begin
      if (!p_en[1]) begin offer(1, ADDR_W'(a1), rand_data(), {$urandom, $urandom}); a1++; end
      if (!p_en[6]) begin offer(6, ADDR_W'(a6), rand_data(), {$urandom, $urandom}); a6++; end
      cycle(1'b0);
    end
    repeat (4) cycle(1'b0);

    // All ports saturated: backpressure on every port.
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NUM_PORTS; i++) offer_rand(i);
      cycle(1'b0);
    end
    repeat (12) cycle(1'b0);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_PORTS; i++)
        if ($urandom_range(0, 99) < 35) offer_rand(i);
      cycle(1'b0);
    end

    // Reset while five entries are pending, then normal traffic again.
    for (int i = 0; i < 5; i++) offer_rand(i);
    cycle(1'b0);
    cycle(1'b0);
    for (int i = 0; i < NUM_PORTS; i++) offer_rand(i);
    cycle(1'b1);
    for (int c = 0; c < 20; c++) begin
      if ($urandom_range(0, 1) == 1) offer_rand($urandom_range(0, NUM_PORTS - 1));
      cycle(1'b0);
    end

    repeat (16) cycle(1'b0);
    @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("wr_pending_drained", 64'(wr_pending), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
